wom_reader: RTL and testbench
=============================

WOM_READER -- requirements
Module: wom_reader

Interface
REQ-001 Parameter DATA_W, default 32: width of each lane word and of px_data.
REQ-002 Parameter ADDR_W, default 32: width of count and mem_addr.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begins a drain when sampled high in IDLE.
REQ-006 count  input  ADDR_W  number of 4-lane words to drain; sampled with start.
REQ-007 mem_rd  output  1  read strobe to the result memory's synchronous read port.
REQ-008 mem_addr  output  ADDR_W  word address for mem_rd.
REQ-009 mem_d1..mem_d4  input  DATA_W each  lane data, valid exactly one cycle after mem_rd.
REQ-010 px_data  output  DATA_W  current output lane word.
REQ-011 px_valid  output  1  px_data valid.
REQ-012 px_ready  input  1  downstream accepts; a beat transfers on px_valid & px_ready at a rising edge.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse at end of a drain.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, WAIT, EMIT and DONE.
- IDLE->FETCH on start with count != 0.
- IDLE->DONE on start with count == 0.
REQ-016 FETCH: mem_rd=1 and mem_addr=word pointer for exactly one cycle, then WAIT.
REQ-017 WAIT: the block SHALL latch mem_d1..mem_d4 into a 4-entry lane buffer, clear the lane index, then go to EMIT.
REQ-018 EMIT: px_valid=1 and px_data=buffer[lane index], lane 1 first.
- Each transfer increments the lane index.
- A transfer on lane 4 goes to DONE if pointer+1 == count; otherwise the pointer increments and the FSM goes to FETCH.
REQ-019 While px_valid=1 and px_ready=0, px_data and px_valid SHALL hold stable; px_valid SHALL never drop without a transfer.
REQ-020 DONE: done=1 for one cycle, then IDLE.
REQ-021 Latency: start sampled at edge k gives mem_rd high in cycle k+1 and the first px_valid in cycle k+3.
REQ-022 Throughput with px_ready held high SHALL be 6 cycles per word (4 beats + FETCH + WAIT).
REQ-023 start asserted outside IDLE SHALL be ignored; count is captured only on the accepted start.
REQ-024 The word pointer starts at 0 and SHALL NOT wrap; the maximum count of 2^ADDR_W-1 drains addresses 0..count-1.
REQ-025 mem_rd SHALL be 0 and mem_addr SHALL hold its last value in every state except FETCH.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, pointer 0, lane index 0, lane buffer 0, mem_rd 0, mem_addr 0, px_data 0, px_valid 0, busy 0, done 0.
REQ-027 A reset mid-drain SHALL abandon the drain with no done pulse; the next start restarts from address 0.

Configuration
REQ-028 Macro WOM_READER_CLAMP_EN defined: each lane SHALL be treated as signed and saturated to 0..255 before px_data; negative gives 0, >255 gives 255.
REQ-029 Macro undefined: px_data SHALL be the raw lane word; the clamp logic SHALL be absent.

Structure
REQ-030 Shared package vasip_mem_pkg SHALL hold the FSM state enum typedef, constant LANES=4 and constants PX_MIN=0 and PX_MAX=255.
REQ-031 Combinational sub-module px_clamp SHALL implement the saturation and be instantiated only under WOM_READER_CLAMP_EN.

Verification
REQ-032 count=1, word0={10,20,30,40}, px_ready=1 -> px_data 10,20,30,40 on consecutive cycles; one mem_rd at addr 0; done one cycle after the last beat.
REQ-033 count=0, start -> done=1 in the next cycle; px_valid and mem_rd never asserted.
REQ-034 count=1, px_ready low for 3 cycles while px_data=20 -> px_data stays 20 and px_valid stays 1; then 30,40 follow.
REQ-035 count=3, px_ready=1 -> mem_addr 0,1,2 in order; 12 beats; done at cycle k+19; a start pulse mid-drain is ignored.
REQ-036 rst_n low during EMIT -> px_valid, busy and mem_rd are 0 immediately; a new start with count=1 reads addr 0.
REQ-037 Lanes {-5, 300, 128, 0} -> px_data 0,255,128,0 with WOM_READER_CLAMP_EN defined; raw values without it.

Source files
------------

// File: rtl/vasip_mem_pkg.sv
// Shared types and constants for the result-memory reader: FSM states,
// lane count and pixel saturation bounds.
package vasip_mem_pkg;

  localparam int LANES  = 4;
  localparam int PX_MIN = 0;
  localparam int PX_MAX = 255;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/wom_reader_if.sv
// Memory read port plus pixel stream of wom_reader; master is the reader side.
// Handshake: a px beat transfers on a rising edge with px_valid & px_ready; while
// px_valid is high and px_ready low, px_valid and px_data stay stable.
interface wom_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_d1;
  logic [DATA_W-1:0] mem_d2;
  logic [DATA_W-1:0] mem_d3;
  logic [DATA_W-1:0] mem_d4;
  logic [DATA_W-1:0] px_data;
  logic              px_valid;
  logic              px_ready;

  modport master (
    output mem_rd, mem_addr, px_data, px_valid,
    input  mem_d1, mem_d2, mem_d3, mem_d4, px_ready
  );

  modport slave (
    input  mem_rd, mem_addr, px_data, px_valid,
    output mem_d1, mem_d2, mem_d3, mem_d4, px_ready
  );

endinterface

// File: rtl/wom_reader_px_clamp.sv
// Signed lane word saturated into the pixel range PX_MIN..PX_MAX.
// Only compiled when WOM_READER_CLAMP_EN is defined.
`ifdef WOM_READER_CLAMP_EN
module px_clamp
  import vasip_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] clamped
);

  always_comb begin
    clamped = raw;
    if (raw[DATA_W-1]) begin
      clamped = DATA_W'(PX_MIN);
    end else if (raw > DATA_W'(PX_MAX)) begin
      clamped = DATA_W'(PX_MAX);
    end
  end

endmodule
`endif

// File: rtl/wom_reader.sv
// Drains count 4-lane words from a synchronous-read result memory into a
// pixel stream. Optional saturation of lanes via WOM_READER_CLAMP_EN.
module wom_reader
  import vasip_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output state_t            fsm_state,
  wom_reader_if.master      bus
);

  localparam int LANE_W = $clog2(LANES);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] count_q;
  logic [LANE_W-1:0] lane;
  logic [DATA_W-1:0] lane_buf [LANES];
  logic [DATA_W-1:0] lane_word;
  logic              beat;
  logic              last_lane;
  logic              last_word;

  assign beat      = (state == EMIT) && bus.px_ready;
  assign last_lane = (lane == LANE_W'(LANES - 1));
  assign last_word = ((ptr + ADDR_W'(1)) == count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (count == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_nx = WAIT;
      WAIT:  state_nx = EMIT;
      EMIT: begin
        if (beat && last_lane) begin
          state_nx = last_word ? DONE : FETCH;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The pointer only moves on the way into FETCH, so it doubles as the held mem_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      count_q <= '0;
      lane    <= '0;
      for (int i = 0; i < LANES; i++) begin
        lane_buf[i] <= '0;
      end
    end else begin
      if ((state == IDLE) && start && (count != '0)) begin
        ptr     <= '0;
        count_q <= count;
      end
      if (state == WAIT) begin
        lane_buf[0] <= bus.mem_d1;
        lane_buf[1] <= bus.mem_d2;
        lane_buf[2] <= bus.mem_d3;
        lane_buf[3] <= bus.mem_d4;
        lane        <= '0;
      end
      if (beat) begin
        lane <= lane + LANE_W'(1);
        if (last_lane && !last_word) begin
          ptr <= ptr + ADDR_W'(1);
        end
      end
    end
  end

  assign lane_word    = lane_buf[lane];
  assign bus.mem_rd   = (state == FETCH);
  assign bus.mem_addr = ptr;
  assign bus.px_valid = (state == EMIT);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign fsm_state    = state;

`ifdef WOM_READER_CLAMP_EN
  px_clamp #(
    .DATA_W(DATA_W)
  ) u_px_clamp (
    .raw     (lane_word),
    .clamped (bus.px_data)
  );
`else
  assign bus.px_data = lane_word;
`endif

endmodule

// File: tb/tb_wom_reader.sv
// Bench for wom_reader: memory model, scenario tasks and a queue-based
// reference of the expected address and pixel streams.
module tb_wom_reader;
  import vasip_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] count = '0;
  logic        busy;
  logic        done;
  state_t      fsm_state;

  wom_reader_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  wom_reader #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state),
    .bus       (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_l [64][4];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] got_addr_q[$];
  int          first_beat;
  int          done_cyc;
  int          done_n;
  logic        rd_s;
  logic [31:0] rd_a;

  // synchronous-read memory: data valid only in the cycle after mem_rd
  initial begin
    bus.mem_d1 = '0;
    bus.mem_d2 = '0;
    bus.mem_d3 = '0;
    bus.mem_d4 = '0;
    forever begin
      @(negedge clk);
      rd_s = bus.mem_rd;
      rd_a = bus.mem_addr;
      @(posedge clk);
      #1;
      if (rd_s) begin
        bus.mem_d1 = mem_l[rd_a[5:0]][0];
        bus.mem_d2 = mem_l[rd_a[5:0]][1];
        bus.mem_d3 = mem_l[rd_a[5:0]][2];
        bus.mem_d4 = mem_l[rd_a[5:0]][3];
      end else begin
        bus.mem_d1 = $urandom;
        bus.mem_d2 = $urandom;
        bus.mem_d3 = $urandom;
        bus.mem_d4 = $urandom;
      end
    end
  end

  function automatic logic [31:0] clamp_ref(input logic [31:0] x);
`ifdef WOM_READER_CLAMP_EN
    if ($signed(x) < 0) return 32'd0;
    if ($signed(x) > 255) return 32'd255;
    return x;
`else
    return x;
`endif
  endfunction

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    exp_addr_q.delete();
    got_addr_q.delete();
    first_beat = -1;
    done_cyc   = -1;
    done_n     = 0;
  endtask

  task automatic expect_drain(input int n);
    for (int w = 0; w < n; w++) begin
      exp_addr_q.push_back(w);
      for (int l = 0; l < 4; l++) exp_q.push_back(clamp_ref(mem_l[w][l]));
    end
  endtask

  task automatic fill_random(input int n);
    for (int w = 0; w < n; w++)
      for (int l = 0; l < 4; l++) mem_l[w][l] = $urandom;
  endtask

  // start sampled at edge k; returns #1 into cycle k+1
  task automatic drive_start(input logic [31:0] n);
    @(posedge clk);
    #1;
    start = 1'b1;
    count = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    count = $urandom;
  endtask

  task automatic sample(input int c);
    @(negedge clk);
    if (bus.mem_rd) got_addr_q.push_back(bus.mem_addr);
    if (bus.px_valid && bus.px_ready) begin
      got_q.push_back(bus.px_data);
      if (first_beat < 0) first_beat = c;
    end
    if (done) begin
      done_n++;
      done_cyc = c;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 7;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    if (bus.px_valid !== 1'b0) begin errors++; $display("FAIL reset_px_valid: got %0b expected 0", bus.px_valid); end
    if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %0b expected 0", bus.mem_rd); end
    if (bus.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", bus.mem_addr); end
    if (bus.px_data !== 32'd0) begin errors++; $display("FAIL reset_px_data: got %0d expected 0", bus.px_data); end
    if (fsm_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    clear_sb();
    mem_l[0] = '{32'd10, 32'd20, 32'd30, 32'd40};
    expect_drain(1);
    bus.px_ready = 1'b1;
    drive_start(1);
    for (int c = 1; c <= 10; c++) begin
      sample(c);
      if (c == 1) begin
        checks++;
        if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL single_rd_cycle: got %0b expected 1", bus.mem_rd); end
      end
      next_cycle();
    end
    checks += 4;
    if (got_addr_q.size() != 1 || got_addr_q[0] !== 32'd0) begin
      errors++; $display("FAIL single_reads: got %0d reads expected 1 at addr 0", got_addr_q.size());
    end
    if (first_beat != 3) begin errors++; $display("FAIL single_latency: got cycle %0d expected 3", first_beat); end
    if (done_n != 1 || done_cyc != 7) begin
      errors++; $display("FAIL single_done: got %0d pulses at %0d expected 1 at 7", done_n, done_cyc);
    end
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_beats: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    clear_sb();
    mem_l[0] = '{32'd10, 32'd20, 32'd30, 32'd40};
    expect_drain(1);
    bus.px_ready = 1'b1;
    drive_start(1);
    for (int c = 1; c <= 14; c++) begin
      sample(c);
      if (c >= 4 && c <= 6) begin
        checks += 2;
        if (bus.px_data !== 32'd20) begin errors++; $display("FAIL stall_data c%0d: got %0d expected 20", c, bus.px_data); end
        if (bus.px_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d: got %0b expected 1", c, bus.px_valid); end
      end
      next_cycle();
      if (c == 3) bus.px_ready = 1'b0;
      if (c == 6) bus.px_ready = 1'b1;
    end
    checks += 2;
    if (done_n != 1 || done_cyc != 10) begin
      errors++; $display("FAIL stall_done: got %0d pulses at %0d expected 1 at 10", done_n, done_cyc);
    end
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_beats: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_multi();
    clear_sb();
    fill_random(3);
    expect_drain(3);
    bus.px_ready = 1'b1;
    drive_start(3);
    for (int c = 1; c <= 24; c++) begin
      sample(c);
      if (c == 22) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL multi_idle: got busy %0b expected 0", busy); end
      end
      next_cycle();
      if (c == 5) begin start = 1'b1; count = 32'd7; end
      if (c == 6) start = 1'b0;
    end
    checks += 3;
    if (done_n != 1 || done_cyc != 19) begin
      errors++; $display("FAIL multi_done: got %0d pulses at %0d expected 1 at 19", done_n, done_cyc);
    end
    if (got_addr_q.size() != exp_addr_q.size()) begin
      errors++; $display("FAIL multi_reads: got %0d expected %0d", got_addr_q.size(), exp_addr_q.size());
    end
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL multi_beats: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < got_addr_q.size(); i++) begin
      checks++;
      if (got_addr_q[i] !== exp_addr_q[i]) begin errors++; $display("FAIL multi_addr[%0d]: got %0d expected %0d", i, got_addr_q[i], exp_addr_q[i]); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL multi_data[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // follows test_multi, so the held address is the last word read there (2)
  task automatic test_zero();
    clear_sb();
    bus.px_ready = 1'b1;
    drive_start(0);
    for (int c = 1; c <= 6; c++) begin
      sample(c);
      if (c == 1) begin
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %0b expected 1", done); end
        if (bus.mem_addr !== 32'd2) begin errors++; $display("FAIL zero_addr_hold: got %0d expected 2", bus.mem_addr); end
      end
      next_cycle();
    end
    checks += 2;
    if (done_n != 1) begin errors++; $display("FAIL zero_pulses: got %0d expected 1", done_n); end
    if (got_addr_q.size() != 0 || got_q.size() != 0) begin
      errors++; $display("FAIL zero_activity: got %0d reads %0d beats expected 0 0", got_addr_q.size(), got_q.size());
    end
  endtask

  task automatic test_clamp();
    clear_sb();
    mem_l[0] = '{32'hFFFF_FFFB, 32'd300, 32'd128, 32'd0};
    expect_drain(1);
    bus.px_ready = 1'b1;
    drive_start(1);
    for (int c = 1; c <= 10; c++) begin
      sample(c);
      next_cycle();
    end
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL clamp_beats: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL clamp_data[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int n;
      int c;
      n = $urandom_range(2, 5);
      clear_sb();
      fill_random(n);
      expect_drain(n);
      bus.px_ready = 1'b1;
      drive_start(n);
      c = 1;
      while (done_n == 0 && c <= 300) begin
        sample(c);
        next_cycle();
        bus.px_ready = ($urandom_range(0, 3) != 0);
        c++;
      end
      bus.px_ready = 1'b1;
      checks += 3;
      if (done_n != 1) begin errors++; $display("FAIL rand_done it%0d: got %0d pulses expected 1", it, done_n); end
      if (got_addr_q.size() != exp_addr_q.size()) begin
        errors++; $display("FAIL rand_reads it%0d: got %0d expected %0d", it, got_addr_q.size(), exp_addr_q.size());
      end
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_beats it%0d: got %0d expected %0d", it, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data it%0d[%0d]: got %0h expected %0h", it, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    fill_random(2);
    bus.px_ready = 1'b1;
    drive_start(2);
    for (int c = 1; c <= 4; c++) sample(c);
    checks++;
    if (bus.px_valid !== 1'b1) begin errors++; $display("FAIL rmid_in_emit: got %0b expected 1", bus.px_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.px_valid !== 1'b0) begin errors++; $display("FAIL rmid_px_valid: got %0b expected 0", bus.px_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b expected 0", busy); end
    if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL rmid_mem_rd: got %0b expected 0", bus.mem_rd); end
    if (done_n != 0) begin errors++; $display("FAIL rmid_no_done: got %0d expected 0", done_n); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_sb();
    expect_drain(1);
    drive_start(1);
    for (int c = 1; c <= 10; c++) begin
      sample(c);
      next_cycle();
    end
    checks += 3;
    if (got_addr_q.size() != 1 || got_addr_q[0] !== 32'd0) begin
      errors++; $display("FAIL rmid_restart_addr: got %0d reads expected 1 at addr 0", got_addr_q.size());
    end
    if (done_n != 1 || done_cyc != 7) begin
      errors++; $display("FAIL rmid_restart_done: got %0d pulses at %0d expected 1 at 7", done_n, done_cyc);
    end
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rmid_beats: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_data[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    bus.px_ready = 1'b1;
    for (int w = 0; w < 64; w++)
      for (int l = 0; l < 4; l++) mem_l[w][l] = '0;
    test_reset();
    test_single();
    test_stall();
    test_multi();
    test_zero();
    test_clamp();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
